// File: rtl/l1i_fetch_resp_model.sv
// l1i_fetch_resp_model
// Synthesizable stand-in for the L1I and ITLB, facing the fetch stage directly.
// Accepted fetch requests come back in order after a fixed latency. Line data is
// read from a preloadable backing array in the response cycle. The block also
// supports a bounded number of in-flight requests, a flush, optional stall
// injection and a small ITLB walk FSM.
//
// Request handshake: a request transfers in any cycle where
// fetch_l1i_if_req_vld_i and fetch_l1i_if_req_rdy_o are both 1. The requester
// holds valid and payload stable until that cycle. Ready does not depend on
// valid. The response side has no ready: resp_vld_o is a one-cycle pulse that
// the fetch stage must take.
module l1i_fetch_resp_model #(
  parameter int FETCH_WIDTH           = 128,
  parameter int IFQ_DEPTH             = 8,
  parameter int L1I_INDEX_WIDTH       = 6,
  parameter int L1I_OFFSET_WIDTH      = 4,
  parameter int L1I_TAG_WIDTH         = 28,
  parameter int MEM_LINES             = 4096,
  parameter int LATENCY               = 2,
  parameter int MAX_OUTSTANDING       = 4,
  parameter int STALL_MODE            = 0,
  parameter int STALL_PERIOD          = 4,
  parameter int ITLB_MISS_CYCLES      = 2,
  parameter int FAULT_EN              = 0,
  parameter logic [L1I_TAG_WIDTH-1:0] FAULT_VTAG = '0,
  parameter int EXCEPTION_CAUSE_WIDTH = 5,
  localparam int IFTW = (IFQ_DEPTH > 1) ? $clog2(IFQ_DEPTH) : 1,
  localparam int AW   = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_l1i_if_req_vld_i,
  output logic                             fetch_l1i_if_req_rdy_o,
  input  logic [L1I_INDEX_WIDTH-1:0]       fetch_l1i_if_req_index_i,
  input  logic [L1I_OFFSET_WIDTH-1:0]      fetch_l1i_if_req_offset_i,
  input  logic [L1I_TAG_WIDTH-1:0]         fetch_l1i_if_req_vtag_i,
  input  logic [IFTW-1:0]                  fetch_l1i_if_req_if_tag_i,
  input  logic                             flush_i,
  output logic                             l1i_fetch_if_resp_vld_o,
  output logic [IFTW-1:0]                  l1i_fetch_if_resp_if_tag_o,
  output logic [FETCH_WIDTH-1:0]           l1i_fetch_if_resp_data_o,
  input  logic                             mem_we_i,
  input  logic [AW-1:0]                    mem_waddr_i,
  input  logic [FETCH_WIDTH-1:0]           mem_wdata_i,
  input  logic                             fetch_itlb_req_vld_i,
  output logic                             itlb_fetch_hit_o,
  output logic                             itlb_fetch_miss_o,
  output logic                             itlb_fetch_resp_excp_vld_o,
  output logic [EXCEPTION_CAUSE_WIDTH-1:0] itlb_fetch_resp_ecause_o,
  output logic [1:0]                       itlb_state_dbg
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int NW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STALL_PERIOD);
  localparam int MW = (ITLB_MISS_CYCLES > 1) ? $clog2(ITLB_MISS_CYCLES) : 1;

  typedef enum logic [1:0] {
    ITLB_IDLE = 2'd0,
    ITLB_WALK = 2'd1,
    ITLB_HIT  = 2'd2
  } itlb_state_t;

  // The offset only selects bytes inside the returned line, so it is not needed here.
  logic unused_offset;
  assign unused_offset = ^fetch_l1i_if_req_offset_i;

  // Backing store
  logic [FETCH_WIDTH-1:0] mem [MEM_LINES];

  // In-flight entries form a circular queue. Each entry has its own countdown
  // to its response cycle.
  logic [IFTW-1:0] e_tag  [MAX_OUTSTANDING];
  logic [AW-1:0]   e_addr [MAX_OUTSTANDING];
  logic [CW-1:0]   e_cnt  [MAX_OUTSTANDING];
  logic [PW-1:0]   head, tail;
  logic [NW-1:0]   count;

  logic [SW-1:0]   stall_cnt;
  logic [15:0]     lfsr;
  logic            stall;

  logic            accept;
  logic            resp_fire;
  logic [AW-1:0]   req_addr;

  itlb_state_t     itlb_state;
  logic [MW-1:0]   walk_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_addr = AW'({fetch_l1i_if_req_vtag_i, fetch_l1i_if_req_index_i});

  // Stall sources: a free-running period counter and a 16-bit Fibonacci LFSR
  // (x^16+x^14+x^13+x^11+1). Both run every cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      lfsr      <= 16'hACE1;
    end else begin
      stall_cnt <= (stall_cnt == SW'(STALL_PERIOD - 1)) ? '0 : stall_cnt + 1'b1;
      lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  // Choose the stall source for the configured mode.
  always_comb begin
    stall = 1'b0;
    if (STALL_MODE == 1) stall = (stall_cnt == SW'(STALL_PERIOD - 1));
    else if (STALL_MODE == 2) stall = lfsr[1] & lfsr[0];
  end

  // A response in this cycle frees its slot at once, so a full queue can still
  // take a new request in that cycle.
  assign resp_fire = (count != '0) & (e_cnt[head] == '0) & ~flush_i & ~rst;
  assign fetch_l1i_if_req_rdy_o = ((count < NW'(MAX_OUTSTANDING)) | resp_fire) &
                                  ~stall & ~flush_i & ~rst;
  assign accept = fetch_l1i_if_req_vld_i & fetch_l1i_if_req_rdy_o;

  // Queue pointers and occupancy. Flush and reset drop everything in flight.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept)    tail <= ptr_inc(tail);
      if (resp_fire) head <= ptr_inc(head);
      count <= count + NW'(accept) - NW'(resp_fire);
    end
  end

  // Entry payloads and countdowns. Stale entries are never reached because
  // count gates the head, so these registers are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (e_cnt[i] != '0) e_cnt[i] <= e_cnt[i] - 1'b1;
    end
    if (accept) begin
      e_tag[tail]  <= fetch_l1i_if_req_if_tag_i;
      e_addr[tail] <= req_addr;
      e_cnt[tail]  <= CW'(LATENCY - 1);
    end
  end

  // Preload port. A response sees a write only after the write's clock edge.
  always_ff @(posedge clk) begin
    if (mem_we_i) mem[mem_waddr_i] <= mem_wdata_i;
  end

  assign l1i_fetch_if_resp_vld_o    = resp_fire;
  assign l1i_fetch_if_resp_if_tag_o = resp_fire ? e_tag[head] : '0;
  assign l1i_fetch_if_resp_data_o   = resp_fire ? mem[e_addr[head]] : '0;

  // ITLB FSM: walk for ITLB_MISS_CYCLES cycles, then hit while the lookup is held.
  always_ff @(posedge clk) begin
    if (rst || !fetch_itlb_req_vld_i) begin
      itlb_state <= ITLB_IDLE;
      walk_cnt   <= '0;
    end else begin
      case (itlb_state)
        ITLB_IDLE: begin
          walk_cnt   <= '0;
          itlb_state <= (ITLB_MISS_CYCLES == 0) ? ITLB_HIT : ITLB_WALK;
        end
        ITLB_WALK: begin
          if (walk_cnt == MW'(ITLB_MISS_CYCLES - 1)) itlb_state <= ITLB_HIT;
          else walk_cnt <= walk_cnt + 1'b1;
        end
        ITLB_HIT: itlb_state <= ITLB_HIT;
        default:  itlb_state <= ITLB_IDLE;
      endcase
    end
  end

  assign itlb_state_dbg             = itlb_state;
  assign itlb_fetch_hit_o           = (itlb_state == ITLB_HIT) & fetch_itlb_req_vld_i & ~rst;
  assign itlb_fetch_miss_o          = ~itlb_fetch_hit_o;
  assign itlb_fetch_resp_excp_vld_o = itlb_fetch_hit_o & (FAULT_EN != 0) &
                                      (fetch_l1i_if_req_vtag_i == FAULT_VTAG);
  assign itlb_fetch_resp_ecause_o   = itlb_fetch_resp_excp_vld_o ?
                                      EXCEPTION_CAUSE_WIDTH'(12) : '0;

endmodule

// File: tb/tb_l1i_fetch_resp_model.sv
// tb_l1i_fetch_resp_model
// Bench for l1i_fetch_resp_model. A reference model tracks every accepted
// request with its absolute due cycle and checks ready, responses, tags and
// data every cycle. Around it are directed sequences and an ITLB vector table.
module tb_l1i_fetch_resp_model;

  localparam int LAT  = 3;
  localparam int MAXO = 2;
  localparam int SPER = 4;
  localparam int MISS = 2;
  localparam logic [27:0] FV = 28'h00BADC0;
  localparam int EW = 47;  // {due[31:0], if_tag[2:0], addr[11:0]}

  logic         clk, rst;
  logic         vld, rdy, flush, mem_we, itlb_req;
  logic [5:0]   index;
  logic [3:0]   offset;
  logic [27:0]  vtag;
  logic [2:0]   if_tag, resp_tag;
  logic         resp_vld;
  logic [127:0] resp_data, mem_wdata;
  logic [11:0]  mem_waddr;
  logic         hit, miss, excp;
  logic [4:0]   ecause;
  logic [1:0]   itlb_dbg;

  l1i_fetch_resp_model #(
    .LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .STALL_MODE(1), .STALL_PERIOD(SPER),
    .ITLB_MISS_CYCLES(MISS), .FAULT_EN(1), .FAULT_VTAG(FV)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_l1i_if_req_vld_i(vld), .fetch_l1i_if_req_rdy_o(rdy),
    .fetch_l1i_if_req_index_i(index), .fetch_l1i_if_req_offset_i(offset),
    .fetch_l1i_if_req_vtag_i(vtag), .fetch_l1i_if_req_if_tag_i(if_tag),
    .flush_i(flush),
    .l1i_fetch_if_resp_vld_o(resp_vld), .l1i_fetch_if_resp_if_tag_o(resp_tag),
    .l1i_fetch_if_resp_data_o(resp_data),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .fetch_itlb_req_vld_i(itlb_req), .itlb_fetch_hit_o(hit), .itlb_fetch_miss_o(miss),
    .itlb_fetch_resp_excp_vld_o(excp), .itlb_fetch_resp_ecause_o(ecause),
    .itlb_state_dbg(itlb_dbg)
  );

  // ---------------- clock / cycle index ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int now = 0;
  always @(posedge clk) now <= now + 1;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_resp_seen = 0;
  int rst_rel = 0;
  logic [EW-1:0] exp_q[$];
  logic [2:0]    seen_tags[$];
  logic [127:0]  mem_m [4096];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  // Reference model. Checked mid-cycle, then advanced with this cycle's inputs.
  always @(negedge clk) begin : ref_model
    logic         e_resp, e_rdy, e_stall;
    logic [EW-1:0] h;
    logic [33:0]  va;
    int           occ;
    if (rst) rst_rel = now + 1;
    e_stall = !rst && ((now - rst_rel) % SPER == SPER - 1);
    e_resp  = !rst && !flush && exp_q.size() > 0 && int'(exp_q[0][46:15]) == now;
    occ     = exp_q.size() - (e_resp ? 1 : 0);
    e_rdy   = !rst && !flush && !e_stall && occ < MAXO;
    chk("rdy", {127'd0, rdy}, {127'd0, e_rdy});
    chk("resp_vld", {127'd0, resp_vld}, {127'd0, e_resp});
    if (resp_vld === 1'b1) begin
      n_resp_seen++;
      seen_tags.push_back(resp_tag);
    end
    if (e_resp) begin
      h = exp_q[0];
      chk("resp_tag", {125'd0, resp_tag}, {125'd0, h[14:12]});
      chk("resp_data", resp_data, mem_m[h[11:0]]);
    end
    if (rst || flush) exp_q.delete();
    else begin
      if (e_resp) void'(exp_q.pop_front());
      if (vld && e_rdy) begin
        va = {vtag, index};
        exp_q.push_back({32'(now + LAT), if_tag, va[11:0]});
      end
    end
    if (mem_we) mem_m[mem_waddr] = mem_wdata;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] idx, input logic [27:0] vt, input logic [2:0] tg,
                      output int acc);
    vld = 1'b1; index = idx; vtag = vt; if_tag = tg; acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk);
      if (rdy) acc = now;
      step();
    end
    vld = 1'b0;
    if (acc < 0) chk("send_timeout", 128'd0, 128'd1);
  endtask

  // Watch the cycles after an accept and check exactly one response at acc+LAT.
  task automatic expect_resp(input int acc, input logic [2:0] tg, input logic [127:0] dat,
                             input string name);
    int cnt, at;
    logic [2:0] t; logic [127:0] d;
    cnt = 0; at = -1; t = '0; d = '0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      if (resp_vld) begin
        cnt++;
        if (at < 0) begin at = now; t = resp_tag; d = resp_data; end
      end
      step();
    end
    chk({name, "_count"}, 128'(cnt), 128'd1);
    chk({name, "_cycle"}, 128'(at), 128'(acc + LAT));
    chk({name, "_tag"}, {125'd0, t}, {125'd0, tg});
    chk({name, "_data"}, d, dat);
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    chk({name, "_resp_vld"}, {127'd0, resp_vld}, 128'd0);
    chk({name, "_resp_tag"}, {125'd0, resp_tag}, 128'd0);
    chk({name, "_resp_data"}, resp_data, 128'd0);
    chk({name, "_hit"}, {127'd0, hit}, 128'd0);
    chk({name, "_miss"}, {127'd0, miss}, 128'd1);
    chk({name, "_excp"}, {127'd0, excp}, 128'd0);
    chk({name, "_ecause"}, {123'd0, ecause}, 128'd0);
    chk({name, "_rdy"}, {127'd0, rdy}, 128'd1);
    step();
  endtask

  // ---------------- ITLB vector table ----------------
  typedef struct {
    logic        req;
    logic [27:0] vt;
    logic        hit;
    logic        excp;
  } itlb_vec_t;
  itlb_vec_t tv[14];

  // ---------------- main sequence ----------------
  initial begin : main
    int acc, n0, k, tries;
    logic took;
    logic [127:0] a0 = {16{8'hA0}};

    tv[0]  = '{1'b1, FV,           1'b0, 1'b0};  // idle
    tv[1]  = '{1'b1, FV,           1'b0, 1'b0};  // walk 0
    tv[2]  = '{1'b1, FV,           1'b0, 1'b0};  // walk 1
    tv[3]  = '{1'b1, FV,           1'b1, 1'b1};  // hit, faulting vtag
    tv[4]  = '{1'b1, 28'h1234567,  1'b1, 1'b0};  // hit, clean vtag
    tv[5]  = '{1'b0, FV,           1'b0, 1'b0};  // lookup dropped
    tv[6]  = '{1'b1, FV,           1'b0, 1'b0};  // idle again
    tv[7]  = '{1'b1, FV,           1'b0, 1'b0};  // walk 0
    tv[8]  = '{1'b0, FV,           1'b0, 1'b0};  // dropped mid-walk
    tv[9]  = '{1'b1, 28'h0000040,  1'b0, 1'b0};  // idle
    tv[10] = '{1'b1, 28'h0000040,  1'b0, 1'b0};  // walk 0
    tv[11] = '{1'b1, 28'h0000040,  1'b0, 1'b0};  // walk 1
    tv[12] = '{1'b1, 28'h0000040,  1'b1, 1'b0};  // hit
    tv[13] = '{1'b1, FV,           1'b1, 1'b1};  // hit, vtag moves to fault

    rst = 1'b1; vld = 1'b0; flush = 1'b0; mem_we = 1'b0; itlb_req = 1'b0;
    index = '0; offset = '0; vtag = '0; if_tag = '0; mem_waddr = '0; mem_wdata = '0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Preload lines 0..15. Line 3 holds the A0 pattern.
    for (int i = 0; i < 16; i++) begin
      mem_we = 1'b1; mem_waddr = 12'(i);
      mem_wdata = (i == 3) ? a0 : {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    mem_we = 1'b0;
    step();

    // Single request to line 3.
    send(6'd3, 28'd0, 3'd5, acc);
    expect_resp(acc, 3'd5, a0, "single");

    // Requests back to back with valid held. This exercises the full queue,
    // freeing a slot on a response, and stalls.
    seen_tags.delete();
    k = 0; tries = 0;
    vld = 1'b1;
    while (k < 8 && tries < 60) begin
      index = 6'(k); vtag = '0; if_tag = 3'(k);
      @(negedge clk);
      if (rdy) k++;
      step();
      tries++;
    end
    vld = 1'b0;
    chk("b2b_timeout", 128'(k), 128'd8);
    repeat (LAT + 2) step();
    chk("b2b_count", 128'(seen_tags.size()), 128'd8);
    for (int i = 0; i < 8 && i < seen_tags.size(); i++)
      chk("b2b_order", {125'd0, seen_tags[i]}, 128'(i));

    // Flush with two requests in flight.
    send(6'd1, 28'd0, 3'd1, acc);
    send(6'd2, 28'd0, 3'd2, acc);
    n0 = n_resp_seen;
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (LAT + 4) step();
    chk("flush_no_resp", 128'(n_resp_seen - n0), 128'd0);
    send(6'd4, 28'd0, 3'd6, acc);
    expect_resp(acc, 3'd6, mem_m[4], "post_flush");

    // ITLB table.
    for (int i = 0; i < 14; i++) begin
      itlb_req = tv[i].req; vtag = tv[i].vt;
      @(negedge clk);
      chk("itlb_hit", {127'd0, hit}, {127'd0, tv[i].hit});
      chk("itlb_miss", {127'd0, miss}, {127'd0, ~tv[i].hit});
      chk("itlb_excp", {127'd0, excp}, {127'd0, tv[i].excp});
      chk("itlb_ecause", {123'd0, ecause}, tv[i].excp ? 128'd12 : 128'd0);
      step();
    end
    itlb_req = 1'b0; vtag = '0;
    step();

    // Random traffic with occasional flushes and preload writes.
    vld = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      took = vld && rdy;
      step();
      flush     = ($urandom_range(0, 39) == 0);
      mem_we    = ($urandom_range(0, 7) == 0);
      mem_waddr = 12'($urandom_range(0, 15));
      mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      if (!vld || took) begin
        vld    = ($urandom_range(0, 2) != 0);
        index  = 6'($urandom_range(0, 15));
        vtag   = 28'($urandom) & 28'hFFFFFC0;
        if_tag = 3'($urandom_range(0, 7));
      end
    end
    vld = 1'b0; flush = 1'b0; mem_we = 1'b0; vtag = '0;
    repeat (LAT + 3) step();

    // Reset while two requests are in flight and the ITLB is in its hit state.
    itlb_req = 1'b1;
    send(6'd5, 28'd0, 3'd3, acc);
    send(6'd6, 28'd0, 3'd4, acc);
    n0 = n_resp_seen;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    itlb_req = 1'b0;
    repeat (LAT + 4) step();
    chk("midrst_no_resp", 128'(n_resp_seen - n0), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
